// File: rtl/clock_time_controller.sv
// Time-keeping and set-mode controller for the digital clock.
// It turns the divider's 1 Hz level into a tick, keeps BCD hh:mm:ss and runs the RUN/SET_HOUR/SET_MIN mode machine.
module clock_time_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_50MHZ,
    input  logic       reset,
    input  logic       clock_1HZ,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       div_enable,
    output logic       div_reset,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_lvl;
    logic                   lvl_prev_p1;
    logic                   tick_p2;

    logic mode_q_p0, mode_prev_p1;
    logic inc_q_p0, inc_prev_p1;
    logic mode_p, inc_p;

    logic [7:0] hour_d, min_d, sec_d;
    logic [8:0] sec_inc, min_inc, hour_inc;

    // Returns {carry, next}; lim is the last legal value before wrapping to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [8:0] r;
        if (v == lim)
            r = {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'h0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign sync_lvl = sync_p0[SYNC_STAGES-1];
    assign mode_p   = mode_q_p0 & ~mode_prev_p1;
    assign inc_p    = inc_q_p0 & ~inc_prev_p1;
    assign mode     = state_q;

    // Stage 0/1/2: synchroniser, edge detect, registered tick; button edge detect.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            sync_p0      <= '0;
            lvl_prev_p1  <= 1'b0;
            tick_p2      <= 1'b0;
            mode_q_p0    <= 1'b0;
            mode_prev_p1 <= 1'b0;
            inc_q_p0     <= 1'b0;
            inc_prev_p1  <= 1'b0;
        end else begin
            sync_p0      <= {sync_p0[SYNC_STAGES-2:0], clock_1HZ};
            lvl_prev_p1  <= sync_lvl;
            tick_p2      <= sync_lvl & ~lvl_prev_p1;
            mode_q_p0    <= mode_btn;
            mode_prev_p1 <= mode_q_p0;
            inc_q_p0     <= inc_btn;
            inc_prev_p1  <= inc_q_p0;
        end
    end

    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mode_p) state_d = SET_HOUR;
            SET_HOUR: if (mode_p) state_d = SET_MIN;
            SET_MIN:  if (mode_p) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        hour_d   = hour_bcd;
        min_d    = min_bcd;
        sec_d    = sec_bcd;
        sec_inc  = bcd_inc(sec_bcd, 8'h59);
        min_inc  = bcd_inc(min_bcd, 8'h59);
        hour_inc = bcd_inc(hour_bcd, 8'h23);
        case (state_q)
            RUN: begin
                // Carries ripple through all three fields in one cycle.
                if (tick_p2) begin
                    sec_d = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        min_d = min_inc[7:0];
                        if (min_inc[8])
                            hour_d = hour_inc[7:0];
                    end
                end
            end
            SET_HOUR: begin
                if (inc_p && !mode_p)
                    hour_d = hour_inc[7:0];
            end
            SET_MIN: begin
                if (mode_p)
                    sec_d = 8'h00;
                else if (inc_p)
                    min_d = min_inc[7:0];
            end
            default: ;
        endcase
    end

    // Stage 3: registered time and status outputs.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            hour_bcd   <= 8'h00;
            min_bcd    <= 8'h00;
            sec_bcd    <= 8'h00;
            div_enable <= 1'b1;
            div_reset  <= 1'b0;
            blink      <= 1'b0;
        end else begin
            hour_bcd   <= hour_d;
            min_bcd    <= min_d;
            sec_bcd    <= sec_d;
            div_enable <= (state_d == RUN);
            div_reset  <= (state_q == SET_MIN) && mode_p;
            blink      <= (state_d != RUN) && sync_lvl;
        end
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller: reset, ticking and carries, set flow, collisions and blink.
module tb_clock_time_controller;

    logic       clk;
    logic       rst;
    logic       clock_1HZ;
    logic       mode_btn;
    logic       inc_btn;
    logic       div_enable;
    logic       div_reset;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic       blink;

    int tests;
    int fails;
    int dr_cycles;

    clock_time_controller #(.SYNC_STAGES(2)) dut (
        .clock_50MHZ(clk),
        .reset      (rst),
        .clock_1HZ  (clock_1HZ),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .div_enable (div_enable),
        .div_reset  (div_reset),
        .hour_bcd   (hour_bcd),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .mode       (mode),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) if (div_reset) dr_cycles++;

    task automatic do_reset();
        clock_1HZ = 1'b0;
        mode_btn  = 1'b0;
        inc_btn   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_mode();
        @(negedge clk) mode_btn = 1'b1;
        @(negedge clk) mode_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) inc_btn = 1'b1;
            @(negedge clk) inc_btn = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clock_1HZ = 1'b1;
            repeat (5) @(negedge clk);
            clock_1HZ = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    // From reset: set hours/minutes via set mode and return to RUN.
    task automatic set_time(input int h, input int m);
        press_mode();
        press_inc(h);
        press_mode();
        press_inc(m);
        press_mode();
    endtask

    task automatic check_time(input string name, input logic [23:0] exp);
        tests++;
        if ({hour_bcd, min_bcd, sec_bcd} !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, {hour_bcd, min_bcd, sec_bcd}, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_time("reset_time", 24'h000000);
        tests++;
        if ({mode, div_enable, div_reset, blink} !== 5'b00100) begin
            fails++;
            $display("FAIL reset_ctrl: got mode=%0d en=%b dr=%b blink=%b required 0 1 0 0",
                     mode, div_enable, div_reset, blink);
        end
    endtask

    task automatic test_tick_latency();
        do_reset();
        @(negedge clk) clock_1HZ = 1'b1;
        repeat (3) @(negedge clk);
        check_time("tick_before_latency", 24'h000000);
        @(negedge clk);
        check_time("tick_at_latency", 24'h000001);
        clock_1HZ = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_carry();
        do_reset();
        send_ticks(9);
        check_time("sec_09", 24'h000009);
        send_ticks(1);
        check_time("sec_carry_10", 24'h000010);
        do_reset();
        set_time(0, 9);
        send_ticks(59);
        check_time("pre_min_carry", 24'h000959);
        send_ticks(1);
        check_time("min_carry", 24'h001000);
    endtask

    task automatic test_set_flow();
        int dr0;
        do_reset();
        press_mode();
        press_inc(25);
        tests++;
        if (hour_bcd !== 8'h01 || div_enable !== 1'b0 || mode !== 2'd1) begin
            fails++;
            $display("FAIL set_hour: got hour=%h en=%b mode=%0d required 01 0 1", hour_bcd, div_enable, mode);
        end
        press_mode();
        press_inc(61);
        tests++;
        if (min_bcd !== 8'h01 || mode !== 2'd2 || div_enable !== 1'b0) begin
            fails++;
            $display("FAIL set_min: got min=%h mode=%0d en=%b required 01 2 0", min_bcd, mode, div_enable);
        end
        dr0 = dr_cycles;
        press_mode();
        tests++;
        if (mode !== 2'd0 || div_enable !== 1'b1 || (dr_cycles - dr0) != 1) begin
            fails++;
            $display("FAIL set_exit: got mode=%0d en=%b div_reset_cycles=%0d required 0 1 1",
                     mode, div_enable, dr_cycles - dr0);
        end
        check_time("set_exit_time", 24'h010100);
    endtask

    task automatic test_rollover();
        int bad;
        do_reset();
        set_time(23, 59);
        send_ticks(59);
        check_time("pre_rollover", 24'h235959);
        bad = 0;
        @(negedge clk) clock_1HZ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({hour_bcd, min_bcd, sec_bcd} != 24'h235959 && {hour_bcd, min_bcd, sec_bcd} != 24'h000000)
                bad++;
        end
        clock_1HZ = 1'b0;
        repeat (4) @(negedge clk);
        check_time("rollover", 24'h000000);
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rollover_glitch: got %0d intermediate cycles required 0", bad);
        end
    endtask

    task automatic test_collision();
        int dr0;
        do_reset();
        send_ticks(5);
        press_mode();
        press_inc(3);
        @(negedge clk) begin mode_btn = 1'b1; inc_btn = 1'b1; end
        @(negedge clk) begin mode_btn = 1'b0; inc_btn = 1'b0; end
        repeat (3) @(negedge clk);
        tests++;
        if (mode !== 2'd2 || hour_bcd !== 8'h03) begin
            fails++;
            $display("FAIL mode_inc_collision: got mode=%0d hour=%h required 2 03", mode, hour_bcd);
        end
        send_ticks(2);
        check_time("tick_in_set_min", 24'h030005);
        dr0 = dr_cycles;
        press_mode();
        check_time("exit_clears_sec", 24'h030000);
        tests++;
        if ((dr_cycles - dr0) != 1) begin
            fails++;
            $display("FAIL div_reset_pulse: got %0d cycles required 1", dr_cycles - dr0);
        end
    endtask

    task automatic test_blink();
        int hi_run;
        do_reset();
        hi_run = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            clock_1HZ = (i % 6) < 3;
            if (blink) hi_run++;
        end
        clock_1HZ = 1'b0;
        tests++;
        if (hi_run != 0) begin
            fails++;
            $display("FAIL blink_run: got %0d high cycles required 0", hi_run);
        end
        press_mode();
        @(negedge clk) clock_1HZ = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (blink !== 1'b1) begin
            fails++;
            $display("FAIL blink_set_high: got %b required 1", blink);
        end
        clock_1HZ = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (blink !== 1'b0) begin
            fails++;
            $display("FAIL blink_set_low: got %b required 0", blink);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_time(12, 34);
        send_ticks(56);
        check_time("preload_123456", 24'h123456);
        press_mode();
        #3 rst = 1'b1;
        #1;
        check_time("async_reset_time", 24'h000000);
        tests++;
        if (mode !== 2'd0 || div_enable !== 1'b1) begin
            fails++;
            $display("FAIL async_reset_ctrl: got mode=%0d en=%b required 0 1", mode, div_enable);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        dr_cycles = 0;
        test_reset();
        test_tick_latency();
        test_carry();
        test_set_flow();
        test_rollover();
        test_collision();
        test_blink();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_time_controller.md
# clock_time_controller

Sequencing controller for the 1 Hz divider chain in the digital clock. It drives the divider's `enable`, consumes the divider's `clock_1HZ` output as a synchronised tick, and keeps BCD hours/minutes/seconds. It also runs the user set-mode state machine (RUN → SET_HOUR → SET_MIN). It sits between the divider chain and the 7-segment display decoders.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth on `clock_1HZ`. Legal range is 2 to 4.

Ports:
- `clock_50MHZ`  in  1  system clock; every register in the block uses it.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clock_1HZ`  in  1  divider chain output, treated as an asynchronous level.
- `mode_btn`  in  1  debounced level; each rising edge advances the mode.
- `inc_btn`  in  1  debounced level; each rising edge increments the selected field.
- `div_enable`  out  1  drives the divider chain `enable`.
- `div_reset`  out  1  one-cycle pulse that restarts the divider phase.
- `hour_bcd`  out  8  hours, tens in [7:4] and units in [3:0], range 00–23.
- `min_bcd`  out  8  minutes, range 00–59.
- `sec_bcd`  out  8  seconds, range 00–59.
- `mode`  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN; 3 is never produced.
- `blink`  out  1  high while in a SET state and the synchronised `clock_1HZ` level is high.

## Operation
- Reset values: `mode`=RUN, all BCD outputs 00, `div_enable`=1, `div_reset`=0, `blink`=0, synchronisers and edge-detect registers 0.
- Tick: `clock_1HZ` passes through `SYNC_STAGES` flops, then a rising-edge detector. The result `tick` is a 1-cycle pulse.
- Buttons: each button has a 1-flop edge detector giving `mode_p` and `inc_p`. There is no synchroniser; the buttons are already debounced in the `clock_50MHZ` domain.

State machine, advanced on `mode_p`:
- RUN → SET_HOUR.
- SET_HOUR → SET_MIN.
- SET_MIN → RUN.

Behaviour in each state:
- RUN:
  - `div_enable`=1.
  - On `tick`: sec+1. At 59 it wraps to 00 and carries to min.
  - min at 59 with a carry wraps to 00 and carries to hour.
  - hour 23 with a carry wraps to 00.
  - All carries resolve in the same cycle, so 23:59:59 becomes 00:00:00 in one step.
- SET_HOUR:
  - `div_enable`=0 and `tick` is ignored.
  - `inc_p` gives hour+1, wrapping 23→00. No carry to other fields.
- SET_MIN:
  - `div_enable`=0 and `tick` is ignored.
  - `inc_p` gives min+1, wrapping 59→00. No carry to hour.
- Leaving SET_MIN (SET_MIN→RUN):
  - sec is cleared to 00.
  - `div_reset` pulses high for exactly one cycle, so the next second is a full period.
- Arithmetic: the BCD units digit wraps 9→0 with a carry into the tens digit. Internal values never leave legal BCD.

Simultaneous events:
- `mode_p` and `inc_p` in the same cycle: the mode change wins and `inc_p` is dropped.
- `tick` and `mode_p` in the same cycle while in RUN: the tick increment is applied and the state moves to SET_HOUR.
- `tick` arriving in a SET state is discarded; it is not queued.
- `reset` asserted mid-operation: all outputs return to their reset values immediately. This is asynchronous and does not wait for a clock edge.

## Timing
- `tick`-driven update: BCD outputs change at the clock edge `SYNC_STAGES`+1 cycles after the first clock edge that samples `clock_1HZ` high. That is 3 cycles for the default.
- Button response: `mode` and BCD outputs update 1 cycle after the first clock edge that samples the button high.
- `div_enable` is a registered output. It falls on the same edge where `mode` leaves RUN and rises on the same edge where `mode` returns to RUN.
- `div_reset` is high for exactly the one cycle starting at the SET_MIN→RUN edge. No other condition asserts it.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset sequence: assert `reset` mid-cycle with the time at 12:34:56 → outputs read 00:00:00, `mode`=0 and `div_enable`=1 before the next clock edge.
- Roll-over: preload 23:59:59 via set mode (sec reached through ticks), then drive one `clock_1HZ` rising edge → 3 cycles later the outputs read 00:00:00 and no intermediate value appears.
- BCD carry: from 00:00:09 send one tick → `sec_bcd`=8'h10. From 00:09:59 send one tick → 00:10:00.
- Set flow:
  - Step 1: send mode, then 25 `inc_btn` pulses → `hour_bcd`=8'h01 (wrapped) and `div_enable`=0.
  - Step 2: send mode, then 61 pulses → `min_bcd`=8'h01.
  - Step 3: send mode → `mode`=0, `sec_bcd`=00 and a single-cycle `div_reset`.
- Collisions:
  - `mode_btn` and `inc_btn` rising in the same cycle in SET_HOUR → `mode`=2 and hour unchanged.
  - A tick in SET_MIN → sec unchanged.
- Blink: in SET_HOUR with `clock_1HZ` toggling → `blink` follows the synchronised level. In RUN → `blink` stays 0.
